// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared sizes, entry record and CDB snoop helper
package reservation_station_pkg;

  localparam int RS_SIZE       = 8;
  localparam int RS_ID_BIT     = 3;
  localparam int ROB_WIDTH_BIT = 4;

  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;
  typedef logic [RS_ID_BIT-1:0]     rs_id_t;
  typedef logic [5:0]               op_t;

  localparam op_t OP_ADD = 6'd1;
  localparam op_t OP_SUB = 6'd2;
  localparam op_t OP_AND = 6'd3;

  typedef struct packed {
    op_t         op;
    logic [31:0] vj;
    logic [31:0] vk;
    rob_id_t     qj;
    rob_id_t     qk;
    logic        qj_pend;
    logic        qk_pend;
    logic [31:0] imm;
    logic [31:0] pc;
    rob_id_t     rob_id;
  } rs_entry_t;

  typedef struct packed {
    logic        pend;
    logic [31:0] val;
  } operand_t;

  // Resolve one operand against both buses; the ALU bus takes precedence on a shared tag.
  function automatic operand_t snoop_operand(
    input logic        pend,
    input rob_id_t     q,
    input logic [31:0] v,
    input logic        alu_ok,
    input rob_id_t     alu_id,
    input logic [31:0] alu_val,
    input logic        lsb_ok,
    input rob_id_t     lsb_id,
    input logic [31:0] lsb_val
  );
    operand_t r;
    r.pend = pend;
    r.val  = v;
    if (pend && alu_ok && (q == alu_id)) begin
      r.pend = 1'b0;
      r.val  = alu_val;
    end else if (pend && lsb_ok && (q == lsb_id)) begin
      r.pend = 1'b0;
      r.val  = lsb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - issue, CDB and ALU dispatch bundle
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic        issue_valid;
  op_t         issue_op;
  rob_id_t     issue_rob_id;
  logic [31:0] issue_vj;
  logic [31:0] issue_vk;
  logic        issue_qj_pend;
  logic        issue_qk_pend;
  rob_id_t     issue_qj;
  rob_id_t     issue_qk;
  logic [31:0] issue_imm;
  logic [31:0] issue_pc;
  logic        rs_full;

  logic        alu_cdb_valid;
  rob_id_t     alu_cdb_rob_id;
  logic [31:0] alu_cdb_value;
  logic        lsb_cdb_valid;
  rob_id_t     lsb_cdb_rob_id;
  logic [31:0] lsb_cdb_value;

  logic        alu_valid;
  op_t         alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [31:0] alu_imm;
  logic [31:0] alu_pc;
  rob_id_t     alu_rob_id;

  modport master (
    output issue_valid, issue_op, issue_rob_id, issue_vj, issue_vk,
           issue_qj_pend, issue_qk_pend, issue_qj, issue_qk, issue_imm, issue_pc,
           alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    input  rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id
  );

  modport slave (
    input  issue_valid, issue_op, issue_rob_id, issue_vj, issue_vk,
           issue_qj_pend, issue_qk_pend, issue_qj, issue_qk, issue_imm, issue_pc,
           alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    output rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id
  );

endinterface

// File: rtl/reservation_station_rs_pick.sv
// rtl/reservation_station_rs_pick.sv - lowest-index priority encoder
module rs_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order ALU issue buffer with dual-CDB operand capture
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  reservation_station_if.slave bus
);

  logic [RS_SIZE-1:0] busy, busy_next, free_vec, ready_vec;
  rs_entry_t          ent      [RS_SIZE];
  rs_entry_t          ent_next [RS_SIZE];
  rs_entry_t          new_ent;
  logic               free_found, ready_found;
  rs_id_t             free_idx, ready_idx;
  logic               issue_fire, dispatch_fire;

  logic        alu_valid_q;
  op_t         alu_op_q;
  logic [31:0] alu_v1_q, alu_v2_q, alu_imm_q, alu_pc_q;
  rob_id_t     alu_rob_id_q;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~busy[i];
      ready_vec[i] = busy[i] & ~ent[i].qj_pend & ~ent[i].qk_pend;
    end
  end

  rs_pick #(.N(RS_SIZE), .W(RS_ID_BIT)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .W(RS_ID_BIT)) u_ready_pick (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign bus.rs_full = &busy;
  assign issue_fire    = bus.issue_valid && free_found && !flush_in;
  assign dispatch_fire = ready_found && !flush_in;

  always_comb begin
    operand_t oj, ok;
    oj = snoop_operand(bus.issue_qj_pend, bus.issue_qj, bus.issue_vj,
                       bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                       bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
    ok = snoop_operand(bus.issue_qk_pend, bus.issue_qk, bus.issue_vk,
                       bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                       bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
    new_ent.op      = bus.issue_op;
    new_ent.vj      = oj.val;
    new_ent.qj_pend = oj.pend;
    new_ent.qj      = bus.issue_qj;
    new_ent.vk      = ok.val;
    new_ent.qk_pend = ok.pend;
    new_ent.qk      = bus.issue_qk;
    new_ent.imm     = bus.issue_imm;
    new_ent.pc      = bus.issue_pc;
    new_ent.rob_id  = bus.issue_rob_id;
  end

  always_comb begin
    operand_t sj, sk;
    busy_next = busy;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_next[i] = ent[i];
      sj = snoop_operand(busy[i] && ent[i].qj_pend, ent[i].qj, ent[i].vj,
                         bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                         bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
      sk = snoop_operand(busy[i] && ent[i].qk_pend, ent[i].qk, ent[i].vk,
                         bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                         bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
      if (busy[i]) begin
        ent_next[i].vj      = sj.val;
        ent_next[i].qj_pend = sj.pend;
        ent_next[i].vk      = sk.val;
        ent_next[i].qk_pend = sk.pend;
      end
    end
    // Free and ready slots are disjoint, so issue and dispatch never collide.
    if (dispatch_fire) busy_next[ready_idx] = 1'b0;
    if (issue_fire) begin
      ent_next[free_idx]  = new_ent;
      busy_next[free_idx] = 1'b1;
    end
    if (flush_in) busy_next = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy         <= '0;
      ent          <= '{default: '0};
      alu_valid_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_v1_q     <= '0;
      alu_v2_q     <= '0;
      alu_imm_q    <= '0;
      alu_pc_q     <= '0;
      alu_rob_id_q <= '0;
    end else if (rdy_in) begin
      busy        <= busy_next;
      ent         <= ent_next;
      alu_valid_q <= dispatch_fire;
      if (dispatch_fire) begin
        alu_op_q     <= ent[ready_idx].op;
        alu_v1_q     <= ent[ready_idx].vj;
        alu_v2_q     <= ent[ready_idx].vk;
        alu_imm_q    <= ent[ready_idx].imm;
        alu_pc_q     <= ent[ready_idx].pc;
        alu_rob_id_q <= ent[ready_idx].rob_id;
      end
    end
  end

  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_v1     = alu_v1_q;
  assign bus.alu_v2     = alu_v2_q;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.alu_pc     = alu_pc_q;
  assign bus.alu_rob_id = alu_rob_id_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic flush_in;
  int   checks;
  int   errors;

  reservation_station_if rs_bus ();

  reservation_station dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (rs_bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rs_bus.issue_valid    = 1'b0;
    rs_bus.issue_op       = '0;
    rs_bus.issue_rob_id   = '0;
    rs_bus.issue_vj       = '0;
    rs_bus.issue_vk       = '0;
    rs_bus.issue_qj_pend  = 1'b0;
    rs_bus.issue_qk_pend  = 1'b0;
    rs_bus.issue_qj       = '0;
    rs_bus.issue_qk       = '0;
    rs_bus.issue_imm      = '0;
    rs_bus.issue_pc       = '0;
    rs_bus.alu_cdb_valid  = 1'b0;
    rs_bus.alu_cdb_rob_id = '0;
    rs_bus.alu_cdb_value  = '0;
    rs_bus.lsb_cdb_valid  = 1'b0;
    rs_bus.lsb_cdb_rob_id = '0;
    rs_bus.lsb_cdb_value  = '0;
    flush_in              = 1'b0;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [3:0] rob,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjp, input logic [3:0] qj,
                             input logic qkp, input logic [3:0] qk);
    rs_bus.issue_valid   = 1'b1;
    rs_bus.issue_op      = op;
    rs_bus.issue_rob_id  = rob;
    rs_bus.issue_vj      = vj;
    rs_bus.issue_vk      = vk;
    rs_bus.issue_qj_pend = qjp;
    rs_bus.issue_qj      = qj;
    rs_bus.issue_qk_pend = qkp;
    rs_bus.issue_qk      = qk;
    rs_bus.issue_imm     = 32'h100 + 32'(rob);
    rs_bus.issue_pc      = 32'h1000 + 32'(rob) * 4;
  endtask

  task automatic flush_clean();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_in = 1'b0;
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid: got %0h want 0", rs_bus.alu_valid); end
    checks++; if (rs_bus.rs_full !== 1'b0) begin errors++; $display("FAIL reset_rs_full: got %0h want 0", rs_bus.rs_full); end
    checks++; if (rs_bus.alu_op !== 6'd0) begin errors++; $display("FAIL reset_alu_op: got %0h want 0", rs_bus.alu_op); end
    checks++; if (rs_bus.alu_rob_id !== 4'd0) begin errors++; $display("FAIL reset_alu_rob_id: got %0h want 0", rs_bus.alu_rob_id); end
    checks++; if (rs_bus.alu_v1 !== 32'd0 || rs_bus.alu_v2 !== 32'd0) begin errors++; $display("FAIL reset_alu_v: got %0h/%0h want 0/0", rs_bus.alu_v1, rs_bus.alu_v2); end
    checks++; if (rs_bus.alu_imm !== 32'd0 || rs_bus.alu_pc !== 32'd0) begin errors++; $display("FAIL reset_alu_imm_pc: got %0h/%0h want 0/0", rs_bus.alu_imm, rs_bus.alu_pc); end
  endtask

  task automatic test_basic_dispatch();
    drive_issue(OP_ADD, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle_inputs();
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0h want 0", rs_bus.alu_valid); end
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h want 1", rs_bus.alu_valid); end
    checks++; if (rs_bus.alu_rob_id !== 4'd3) begin errors++; $display("FAIL basic_rob_id: got %0h want 3", rs_bus.alu_rob_id); end
    checks++; if (rs_bus.alu_v1 !== 32'd5 || rs_bus.alu_v2 !== 32'd7) begin errors++; $display("FAIL basic_operands: got %0h/%0h want 5/7", rs_bus.alu_v1, rs_bus.alu_v2); end
    checks++; if (rs_bus.alu_op !== OP_ADD) begin errors++; $display("FAIL basic_op: got %0h want 1", rs_bus.alu_op); end
    checks++; if (rs_bus.alu_imm !== 32'h103 || rs_bus.alu_pc !== 32'h100c) begin errors++; $display("FAIL basic_imm_pc: got %0h/%0h want 103/100c", rs_bus.alu_imm, rs_bus.alu_pc); end
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %0h want 0", rs_bus.alu_valid); end
    checks++; if (rs_bus.alu_rob_id !== 4'd3) begin errors++; $display("FAIL basic_payload_hold: got %0h want 3", rs_bus.alu_rob_id); end
  endtask

  task automatic test_cdb_wakeup();
    drive_issue(OP_SUB, 4'd5, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL wakeup_stall_%0d: got %0h want 0", i, rs_bus.alu_valid); end
    end
    rs_bus.alu_cdb_valid  = 1'b1;
    rs_bus.alu_cdb_rob_id = 4'd2;
    rs_bus.alu_cdb_value  = 32'h1234;
    tick();
    idle_inputs();
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL wakeup_capture_cycle: got %0h want 0", rs_bus.alu_valid); end
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_rob_id !== 4'd5) begin errors++; $display("FAIL wakeup_dispatch: got valid %0h rob %0h want 1/5", rs_bus.alu_valid, rs_bus.alu_rob_id); end
    checks++; if (rs_bus.alu_v1 !== 32'h1234 || rs_bus.alu_v2 !== 32'd1) begin errors++; $display("FAIL wakeup_operands: got %0h/%0h want 1234/1", rs_bus.alu_v1, rs_bus.alu_v2); end
    tick();
  endtask

  task automatic test_issue_bypass();
    drive_issue(OP_AND, 4'd6, 32'd0, 32'd2, 1'b1, 4'd4, 1'b0, 4'd0);
    rs_bus.lsb_cdb_valid  = 1'b1;
    rs_bus.lsb_cdb_rob_id = 4'd4;
    rs_bus.lsb_cdb_value  = 32'd9;
    tick();
    idle_inputs();
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_rob_id !== 4'd6) begin errors++; $display("FAIL bypass_dispatch: got valid %0h rob %0h want 1/6", rs_bus.alu_valid, rs_bus.alu_rob_id); end
    checks++; if (rs_bus.alu_v1 !== 32'd9) begin errors++; $display("FAIL bypass_v1: got %0h want 9", rs_bus.alu_v1); end
    tick();
    drive_issue(OP_ADD, 4'd7, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd8);
    tick();
    idle_inputs();
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL both_bus_stall: got %0h want 0", rs_bus.alu_valid); end
    rs_bus.alu_cdb_valid  = 1'b1;
    rs_bus.alu_cdb_rob_id = 4'd8;
    rs_bus.alu_cdb_value  = 32'hAA;
    rs_bus.lsb_cdb_valid  = 1'b1;
    rs_bus.lsb_cdb_rob_id = 4'd8;
    rs_bus.lsb_cdb_value  = 32'hBB;
    tick();
    idle_inputs();
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_v2 !== 32'hAA) begin errors++; $display("FAIL alu_bus_wins: got valid %0h v2 %0h want 1/aa", rs_bus.alu_valid, rs_bus.alu_v2); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive_issue(OP_ADD, 4'(10 + i), 32'(i), 32'(i + 1), 1'b0, 4'd0, 1'b0, 4'd0);
      else idle_inputs();
      tick();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_rob_id !== 4'(9 + i)) begin
          errors++;
          $display("FAIL b2b_dispatch_%0d: got valid %0h rob %0h want 1/%0h", i, rs_bus.alu_valid, rs_bus.alu_rob_id, 9 + i);
        end
      end
    end
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0h want 0", rs_bus.alu_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      drive_issue(OP_SUB, 4'(i), 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0);
      tick();
      if (i == 6) begin
        checks++; if (rs_bus.rs_full !== 1'b0) begin errors++; $display("FAIL full_seven: got %0h want 0", rs_bus.rs_full); end
      end
    end
    idle_inputs();
    checks++; if (rs_bus.rs_full !== 1'b1) begin errors++; $display("FAIL full_eight: got %0h want 1", rs_bus.rs_full); end
    drive_issue(OP_ADD, 4'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle_inputs();
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b0 || rs_bus.rs_full !== 1'b1) begin errors++; $display("FAIL full_ninth_ignored: got valid %0h full %0h want 0/1", rs_bus.alu_valid, rs_bus.rs_full); end
    rs_bus.alu_cdb_valid  = 1'b1;
    rs_bus.alu_cdb_rob_id = 4'd13;
    rs_bus.alu_cdb_value  = 32'h55;
    tick();
    idle_inputs();
    checks++; if (rs_bus.rs_full !== 1'b1 || rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL full_wake_cycle: got full %0h valid %0h want 1/0", rs_bus.rs_full, rs_bus.alu_valid); end
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_rob_id !== 4'd5 || rs_bus.alu_v1 !== 32'h55) begin errors++; $display("FAIL full_wake_dispatch: got valid %0h rob %0h v1 %0h want 1/5/55", rs_bus.alu_valid, rs_bus.alu_rob_id, rs_bus.alu_v1); end
    checks++; if (rs_bus.rs_full !== 1'b0) begin errors++; $display("FAIL full_relieved: got %0h want 0", rs_bus.rs_full); end
    flush_clean();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      drive_issue(OP_ADD, 4'(i), 32'd0, 32'd0, 1'b1, 4'(8 + i), 1'b0, 4'd0);
      tick();
    end
    idle_inputs();
    flush_in = 1'b1;
    drive_issue(OP_ADD, 4'd12, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    rs_bus.alu_cdb_valid  = 1'b1;
    rs_bus.alu_cdb_rob_id = 4'd8;
    rs_bus.alu_cdb_value  = 32'h77;
    tick();
    idle_inputs();
    checks++; if (rs_bus.alu_valid !== 1'b0 || rs_bus.rs_full !== 1'b0) begin errors++; $display("FAIL flush_state: got valid %0h full %0h want 0/0", rs_bus.alu_valid, rs_bus.rs_full); end
    for (int i = 0; i < 5; i++) begin
      rs_bus.alu_cdb_valid  = 1'b1;
      rs_bus.alu_cdb_rob_id = 4'(8 + (i % 4));
      rs_bus.alu_cdb_value  = 32'h66;
      tick();
      checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale_%0d: got valid %0h rob %0h want 0", i, rs_bus.alu_valid, rs_bus.alu_rob_id); end
    end
    idle_inputs();
    drive_issue(OP_ADD, 4'd14, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle_inputs();
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_rob_id !== 4'd14) begin errors++; $display("FAIL flush_reuse: got valid %0h rob %0h want 1/e", rs_bus.alu_valid, rs_bus.alu_rob_id); end
    tick();
  endtask

  task automatic test_pause();
    drive_issue(OP_ADD, 4'd4, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0);
    tick();
    drive_issue(OP_SUB, 4'd2, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive_issue(OP_AND, 4'd6, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    rdy_in                = 1'b0;
    flush_in              = 1'b1;
    rs_bus.alu_cdb_valid  = 1'b1;
    rs_bus.alu_cdb_rob_id = 4'd9;
    rs_bus.alu_cdb_value  = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rs_bus.alu_valid !== 1'b0 || rs_bus.alu_rob_id !== 4'd14) begin errors++; $display("FAIL pause_frozen_%0d: got valid %0h rob %0h want 0/e", i, rs_bus.alu_valid, rs_bus.alu_rob_id); end
    end
    idle_inputs();
    rdy_in = 1'b1;
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b1 || rs_bus.alu_rob_id !== 4'd2) begin errors++; $display("FAIL pause_resume: got valid %0h rob %0h want 1/2", rs_bus.alu_valid, rs_bus.alu_rob_id); end
    checks++; if (rs_bus.alu_v1 !== 32'hA || rs_bus.alu_v2 !== 32'hB) begin errors++; $display("FAIL pause_operands: got %0h/%0h want a/b", rs_bus.alu_v1, rs_bus.alu_v2); end
    tick();
    checks++; if (rs_bus.alu_valid !== 1'b0) begin errors++; $display("FAIL pause_ignored_traffic: got valid %0h rob %0h want 0", rs_bus.alu_valid, rs_bus.alu_rob_id); end
    flush_clean();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_dispatch();
    test_cdb_wakeup();
    test_issue_bypass();
    test_back_to_back();
    test_full();
    test_flush();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
